// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator request scheduler slice.
// Optional build macro used by the scheduler: DOOR_HOLD_EN.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DISPATCH,
      TRAVEL,
      DWELL
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int DEF_NUM_FLOORS   = 5;
   localparam int DEF_FLOOR_W      = 3;
   localparam int DEF_DWELL_CYCLES = 100;

endpackage

// File: rtl/elevator_target_select.sv
// Combinational nearest-above / nearest-below pending floor finder.
// A cur_floor outside the building reports no match on every output.
module elevator_target_select
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS,
   parameter int FLOOR_W    = DEF_FLOOR_W
) (
   input  logic [NUM_FLOORS-1:0] i_pend,
   input  logic [FLOOR_W-1:0]    i_cur,
   output logic [FLOOR_W-1:0]    o_above,
   output logic [FLOOR_W-1:0]    o_below,
   output logic                  o_any_above,
   output logic                  o_any_below,
   output logic                  o_here
);

   logic w_valid;

   always_comb begin
      w_valid     = (int'(i_cur) < NUM_FLOORS);
      o_above     = '0;
      o_below     = '0;
      o_any_above = 1'b0;
      o_any_below = 1'b0;
      o_here      = 1'b0;
      // Scan top-down so the lowest floor above cur wins.
      for (int i = NUM_FLOORS-1; i >= 0; i--) begin
         if (w_valid && i_pend[i] && (i > int'(i_cur))) begin
            o_above     = FLOOR_W'(i);
            o_any_above = 1'b1;
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (w_valid && i_pend[i] && (i < int'(i_cur))) begin
            o_below     = FLOOR_W'(i);
            o_any_below = 1'b1;
         end
         if (w_valid && i_pend[i] && (i == int'(i_cur)))
            o_here = 1'b1;
      end
   end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN elevator scheduler: sticky call latching, target dispatch, door dwell.
// Build macro DOOR_HOLD_EN adds a door_hold input that restarts the dwell.
module elevator_request_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
   parameter int FLOOR_W      = DEF_FLOOR_W,
   parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_FLOORS-1:0] hall_up_req,
   input  logic [NUM_FLOORS-1:0] hall_dn_req,
   input  logic [NUM_FLOORS-1:0] car_req,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  arrive,
   output logic                  target_valid,
   input  logic                  target_ready,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  target_dir,
   output logic                  door_open,
`ifdef DOOR_HOLD_EN
   input  logic                  door_hold,
`endif
   output logic                  sweep_dir,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES-1);
   localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
   localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

   state_t                r_state;
   logic [NUM_FLOORS-1:0] r_up, r_dn, r_car;
   logic                  r_tvalid, r_tdir, r_door, r_sweep, r_serve;
   logic [FLOOR_W-1:0]    r_tfloor;
   logic [CNT_W-1:0]      r_cnt;

   logic [NUM_FLOORS-1:0] w_pend, w_cur_oh, w_abs_up, w_abs_dn, w_abs_car;
   logic [FLOOR_W-1:0]    w_above, w_below;
   logic                  w_any_above, w_any_below, w_here;
   logic                  w_serve, w_enter_dwell, w_abs_on, w_abs_dir;

   assign w_pend = r_up | r_dn | r_car;

   elevator_target_select #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_sel (
      .i_pend      (w_pend),
      .i_cur       (cur_floor),
      .o_above     (w_above),
      .o_below     (w_below),
      .o_any_above (w_any_above),
      .o_any_below (w_any_below),
      .o_here      (w_here)
   );

   always_comb begin
      w_cur_oh = '0;
      for (int i = 0; i < NUM_FLOORS; i++)
         w_cur_oh[i] = (int'(cur_floor) == i);

      w_serve = r_sweep ? (w_any_above ? DIR_UP : DIR_DOWN)
                        : (w_any_below ? DIR_DOWN : DIR_UP);
      if (int'(cur_floor) == NUM_FLOORS-1) w_serve = DIR_DOWN;
      if (cur_floor == '0)                 w_serve = DIR_UP;

      w_enter_dwell = ((r_state == IDLE) && w_here) ||
                      ((r_state == TRAVEL) && arrive && (cur_floor == r_tfloor));

      // The stop's own calls are cleared on entry and ignored for the whole dwell.
      w_abs_on  = (r_state == DWELL) || w_enter_dwell;
      w_abs_dir = (r_state == DWELL) ? r_serve : w_serve;
      w_abs_up  = (w_abs_on && (w_abs_dir == DIR_UP))   ? w_cur_oh : '0;
      w_abs_dn  = (w_abs_on && (w_abs_dir == DIR_DOWN)) ? w_cur_oh : '0;
      w_abs_car = w_abs_on ? w_cur_oh : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_up  <= '0;
         r_dn  <= '0;
         r_car <= '0;
      end else begin
         r_up  <= (r_up  | (hall_up_req & UP_MASK)) & ~w_abs_up;
         r_dn  <= (r_dn  | (hall_dn_req & DN_MASK)) & ~w_abs_dn;
         r_car <= (r_car | car_req)                 & ~w_abs_car;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_tvalid <= 1'b0;
         r_tfloor <= '0;
         r_tdir   <= DIR_DOWN;
         r_door   <= 1'b0;
         r_sweep  <= DIR_UP;
         r_serve  <= DIR_UP;
         r_cnt    <= '0;
      end else begin
         if (w_enter_dwell) begin
            r_state <= DWELL;
            r_door  <= 1'b1;
            r_cnt   <= '0;
            r_serve <= w_serve;
            r_sweep <= w_serve;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_any_above || w_any_below) begin
                     r_state  <= DISPATCH;
                     r_tvalid <= 1'b1;
                     if (((r_sweep == DIR_UP) && w_any_above) || !w_any_below) begin
                        r_tfloor <= w_above;
                        r_tdir   <= DIR_UP;
                        r_sweep  <= DIR_UP;
                     end else begin
                        r_tfloor <= w_below;
                        r_tdir   <= DIR_DOWN;
                        r_sweep  <= DIR_DOWN;
                     end
                  end
               end
               DISPATCH: begin
                  if (target_ready) begin
                     r_tvalid <= 1'b0;
                     r_state  <= TRAVEL;
                  end
               end
               TRAVEL: ;
               DWELL: begin
`ifdef DOOR_HOLD_EN
                  if (door_hold)
                     r_cnt <= '0;
                  else
`endif
                  if (r_cnt == CNT_LAST) begin
                     r_door  <= 1'b0;
                     r_cnt   <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign target_valid = r_tvalid;
   assign target_floor = r_tfloor;
   assign target_dir   = r_tdir;
   assign door_open    = r_door;
   assign sweep_dir    = r_sweep;
   assign pending      = w_pend;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler; define DOOR_HOLD_EN to also
// exercise the door-hold extension.
module tb_elevator_request_scheduler;

   localparam int NF = 5;
   localparam int FW = 3;
   localparam int DW = 100;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NF-1:0] hall_up_req, hall_dn_req, car_req, pending;
   logic [FW-1:0] cur_floor, target_floor;
   logic          arrive, target_valid, target_ready, target_dir, door_open, sweep_dir;
`ifdef DOOR_HOLD_EN
   logic          door_hold;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_open;

   always #5 clk = ~clk;

   elevator_request_scheduler #(
      .NUM_FLOORS   (NF),
      .FLOOR_W      (FW),
      .DWELL_CYCLES (DW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .hall_up_req  (hall_up_req),
      .hall_dn_req  (hall_dn_req),
      .car_req      (car_req),
      .cur_floor    (cur_floor),
      .arrive       (arrive),
      .target_valid (target_valid),
      .target_ready (target_ready),
      .target_floor (target_floor),
      .target_dir   (target_dir),
      .door_open    (door_open),
`ifdef DOOR_HOLD_EN
      .door_hold    (door_hold),
`endif
      .sweep_dir    (sweep_dir),
      .pending      (pending)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      hall_up_req  = '0;
      hall_dn_req  = '0;
      car_req      = '0;
      arrive       = 1'b0;
      target_ready = 1'b0;
`ifdef DOOR_HOLD_EN
      door_hold    = 1'b0;
`endif
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   // Counts door_open-high cycles starting at the current negedge.
   task automatic count_open(output int n);
      n = 0;
      while (door_open && n < 400) begin
         n++;
         tick(1);
      end
   endtask

   initial begin
      cur_floor = '0;
      do_reset();
      chk("rst_valid", 32'(target_valid), 0);
      chk("rst_floor", 32'(target_floor), 0);
      chk("rst_dir",   32'(target_dir),   0);
      chk("rst_door",  32'(door_open),    0);
      chk("rst_sweep", 32'(sweep_dir),    1);
      chk("rst_pend",  32'(pending),      0);

      // Single car call from floor 0 to floor 3.
      car_req = 5'b01000;
      tick(1);
      car_req = '0;
      chk("t2_latch_pend",  32'(pending),      32'h08);
      chk("t2_latch_valid", 32'(target_valid), 0);
      tick(1);
      chk("t2_valid", 32'(target_valid), 1);
      chk("t2_floor", 32'(target_floor), 3);
      chk("t2_dir",   32'(target_dir),   1);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t2_hold_valid", 32'(target_valid), 1);
         chk("t2_hold_floor", 32'(target_floor), 3);
      end
      target_ready = 1'b1;
      tick(1);
      target_ready = 1'b0;
      chk("t2_drop_valid", 32'(target_valid), 0);
      cur_floor = 3'd2;
      arrive    = 1'b1;
      tick(1);
      arrive = 1'b0;
      chk("t2_wrong_arrive", 32'(door_open), 0);
      cur_floor = 3'd3;
      arrive    = 1'b1;
      tick(1);
      arrive = 1'b0;
      chk("t2_door",  32'(door_open), 1);
      chk("t2_sweep", 32'(sweep_dir), 0);
      count_open(n_open);
      chk("t2_dwell_len", 32'(n_open), DW);
      chk("t2_pend_done", 32'(pending), 0);

      // Sweep up to 4 first, then reverse to 0.
      do_reset();
      cur_floor   = 3'd2;
      car_req     = 5'b10000;
      hall_up_req = 5'b00001;
      tick(1);
      car_req     = '0;
      hall_up_req = '0;
      tick(1);
      chk("t3_floor", 32'(target_floor), 4);
      chk("t3_dir",   32'(target_dir),   1);
      target_ready = 1'b1;
      tick(1);
      target_ready = 1'b0;
      cur_floor    = 3'd4;
      arrive       = 1'b1;
      tick(1);
      arrive = 1'b0;
      chk("t3_door4",  32'(door_open), 1);
      chk("t3_sweep4", 32'(sweep_dir), 0);
      count_open(n_open);
      chk("t3_dwell_len", 32'(n_open), DW);
      chk("t3_pend",      32'(pending), 32'h01);
      tick(1);
      chk("t3_valid2", 32'(target_valid), 1);
      chk("t3_floor2", 32'(target_floor), 0);
      chk("t3_dir2",   32'(target_dir),   0);
      target_ready = 1'b1;
      tick(1);
      target_ready = 1'b0;
      cur_floor    = 3'd0;
      arrive       = 1'b1;
      tick(1);
      arrive = 1'b0;
      chk("t3_door0", 32'(door_open), 1);
      car_req = 5'b01000;
      tick(1);
      car_req = '0;
      chk("t3_pend_mid", 32'(pending), 32'h08);

      // Asynchronous reset in the middle of a dwell.
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_door",  32'(door_open),    0);
      chk("rst_mid_pend",  32'(pending),      0);
      chk("rst_mid_valid", 32'(target_valid), 0);
      chk("rst_mid_sweep", 32'(sweep_dir),    1);

      // Absorb rule at floor 2 while serving up.
      do_reset();
      cur_floor = 3'd2;
      car_req   = 5'b10100;
      tick(1);
      car_req = '0;
      tick(1);
      chk("t4_door",  32'(door_open), 1);
      chk("t4_sweep", 32'(sweep_dir), 1);
      chk("t4_pend",  32'(pending),   32'h10);
      hall_up_req = 5'b00100;
      tick(1);
      hall_up_req = '0;
      chk("t4_absorb_up", 32'(pending), 32'h10);
      hall_dn_req = 5'b00100;
      tick(1);
      hall_dn_req = '0;
      chk("t4_latch_dn", 32'(pending), 32'h14);

      // Top floor: direct dwell, down service, hall-up at top masked.
      do_reset();
      cur_floor   = 3'd4;
      hall_dn_req = 5'b10000;
      car_req     = 5'b10000;
      hall_up_req = 5'b10000;
      tick(1);
      hall_dn_req = '0;
      car_req     = '0;
      hall_up_req = '0;
      chk("t5_pend", 32'(pending), 32'h10);
      tick(1);
      chk("t5_door",  32'(door_open), 1);
      chk("t5_sweep", 32'(sweep_dir), 0);
      chk("t5_clear", 32'(pending),   0);
      hall_up_req = 5'b10000;
      tick(1);
      hall_up_req = '0;
      chk("t5_up_top", 32'(pending), 0);

      // Out-of-range cur_floor never selects or dwells.
      do_reset();
      cur_floor = 3'd7;
      car_req   = 5'b00010;
      tick(1);
      car_req = '0;
      tick(4);
      chk("t6_valid", 32'(target_valid), 0);
      chk("t6_door",  32'(door_open),    0);
      chk("t6_pend",  32'(pending),      32'h02);

`ifdef DOOR_HOLD_EN
      do_reset();
      cur_floor = 3'd1;
      car_req   = 5'b00010;
      tick(1);
      car_req = '0;
      tick(1);
      chk("t7_door", 32'(door_open), 1);
      tick(20);
      door_hold = 1'b1;
      tick(50);
      door_hold = 1'b0;
      chk("t7_held", 32'(door_open), 1);
      count_open(n_open);
      chk("t7_after_hold", 32'(n_open), DW);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Collects hall-call (up/down) and car-call buttons into sticky pending sets.
- Picks the next target floor with a SCAN (sweep) policy and dispatches it to the car motion controller over a valid/ready handshake.
- Runs the door-dwell interval at each stop.
- Sits between the button panels and the motion controller; it owns all request bookkeeping, so the motion controller only moves to a commanded floor.

Parameters:
- NUM_FLOORS, 5, number of floors (floor 0 = bottom).
- FLOOR_W, 3, floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS.
- DWELL_CYCLES, 100, door-open cycles per stop (>= 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- hall_up_req  in  NUM_FLOORS  hall up buttons, level; bit NUM_FLOORS-1 ignored.
- hall_dn_req  in  NUM_FLOORS  hall down buttons, level; bit 0 ignored.
- car_req  in  NUM_FLOORS  in-car floor buttons, level.
- cur_floor  in  FLOOR_W  current car floor from the motion controller.
- arrive  in  1  1-cycle pulse: car stopped at cur_floor.
- target_valid  out  1  target command valid.
- target_ready  in  1  motion controller accepts the target.
- target_floor  out  FLOOR_W  commanded floor.
- target_dir  out  1  1 = up, 0 = down.
- door_open  out  1  door-open command during dwell.
- sweep_dir  out  1  current SCAN direction, 1 = up.
- pending  out  NUM_FLOORS  OR of the up, down and car pending bits per floor.

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE; all pending bits cleared.
  - target_valid=0, target_floor=0, target_dir=0, door_open=0, sweep_dir=1, dwell counter=0.
  - Reset mid-operation aborts any dispatch or dwell immediately.
- Latching:
  - Each cycle, any asserted valid button sets its pending bit.
  - A set and a clear on the same bit in the same cycle: set wins, except the absorb rule in DWELL.
- Selection (combinational, from pending OR per floor):
  - above = nearest pending floor > cur_floor.
  - below = nearest pending floor < cur_floor.
- IDLE:
  - No pending: stay in IDLE.
  - Pending at cur_floor: go to DWELL next cycle.
  - Otherwise, if sweep_dir=1 and above exists: target=above.
  - Otherwise, if below exists: target=below and sweep_dir<=0.
  - Otherwise: target=above and sweep_dir<=1.
  - Mirror the above when sweep_dir=0.
  - After choosing a target, go to DISPATCH.
- DISPATCH:
  - target_valid=1; target_floor and target_dir stay stable until target_ready is sampled high.
  - Then target_valid<=0 next cycle and go to TRAVEL.
  - New requests do not change a pending command.
- TRAVEL:
  - Wait for arrive with cur_floor==target_floor, then go to DWELL.
  - An arrive at any other floor is ignored.
- DWELL:
  - On entry, compute serve_dir: sweep_dir if pending exists beyond cur_floor in sweep_dir, else the reversed direction. sweep_dir <= serve_dir.
  - Clear car_req bit and hall bit for cur_floor in serve_dir (the hall_up bit if serve_dir=1, else hall_dn).
  - door_open=1 for exactly DWELL_CYCLES cycles, counter 0..DWELL_CYCLES-1.
  - While in DWELL, presses at cur_floor matching serve_dir, or the car button for cur_floor, are absorbed (not latched).
  - At terminal count: door_open<=0 and go to IDLE.
  - IDLE to DWELL to IDLE minimum round trip is DWELL_CYCLES+2 cycles.
- Boundaries:
  - At top floor serve_dir is forced to 0; at bottom floor it is forced to 1.
  - cur_floor >= NUM_FLOORS is treated as no match: no dwell, no selection, stay in IDLE.
- Latency: button press to target_valid is 2 cycles from IDLE (latch, then select).

Optional Feature:
- DOOR_HOLD_EN defined:
  - Adds input port door_hold (1 bit).
  - In DWELL, door_hold=1 reloads the dwell counter to 0, keeping door_open high until DWELL_CYCLES cycles after door_hold drops.
- DOOR_HOLD_EN undefined: port absent; dwell is fixed length.

Decomposition:
- Shared package elevator_pkg:
  - State enum: IDLE, DISPATCH, TRAVEL, DWELL.
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Default NUM_FLOORS/FLOOR_W constants.
- Sub-module elevator_target_select:
  - Combinational nearest-above/nearest-below finder plus any_above/any_below/here flags, parameterised on NUM_FLOORS.
  - Reused by the scheduler's IDLE and DWELL logic.

Test Plan:
- Reset mid-DWELL (door_open=1, reset_n=0): all outputs return to reset values asynchronously; pending reads 0.
- cur_floor=0, car_req[3] pulsed 1 cycle:
  - target_valid=1 with target_floor=3, target_dir=1 two cycles later; held through 5 cycles of target_ready=0.
  - arrive at floor 3 gives door_open for 100 cycles, then pending=0.
- cur_floor=2, sweep up, pending floors 4 and 0: first target 4; after dwell at 4, sweep_dir=0 and next target=0.
- Car at floor 2 in DWELL serving up; hall_up_req[2] pressed: absorbed, pending[2]=0. hall_dn_req[2] pressed: latched, pending[2]=1.
- Top floor 4: hall_dn_req[4] and car_req[4] pending with cur_floor=4: direct DWELL, serve_dir=0, both cleared; hall_up_req[4] pressed: never latched.
- With DOOR_HOLD_EN: door_hold high 50 cycles mid-dwell extends door_open to exactly 100 cycles after door_hold falls.
